w0rm_core_imem_port: RTL and testbench
======================================

Name: w0rm_core_imem_port

Overview:
Instruction-memory request/response stage directly upstream of the core instruction-fetch stage. It takes the fetch PC and request-valid produced by the fetch stage and issues word-aligned reads on the instruction bus. It extracts the addressed 16-bit halfword from each response and buffers it. It presents buffered instructions on the fetch stage's instruction inputs (data/valid/addr) and discards in-flight reads on branch flush.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, instruction bus data width; fixed at 32 (two instructions per word)
INST_WIDTH, 16, instruction width
MAX_OUTSTANDING, 2, accepted-but-unanswered bus reads; power of 2, ≥1
FIFO_DEPTH, 2, output instruction buffer entries; power of 2, ≥1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
reg_pc  in  ADDR_WIDTH  fetch PC from fetch stage
reg_pc_valid  in  1  fetch stage requests reg_pc
ifetch_ready  in  1  fetch stage consumes head instruction this cycle
branch_flush  in  1  discard all buffered/in-flight/pending fetches
mem_addr  out  ADDR_WIDTH  word-aligned read address
mem_read_valid  out  1  read request pending
mem_ready  in  1  bus accepts request this cycle
mem_data  in  DATA_WIDTH  read data
mem_data_valid  in  1  read data valid; in-order, ≥1 cycle after accept
inst_data_out  out  INST_WIDTH  head instruction
inst_valid_out  out  1  FIFO non-empty
inst_addr_out  out  ADDR_WIDTH  byte address of head instruction
imem_busy  out  1  any request pending, outstanding, or discard in progress

Behaviour:
- Reset (async, active-high): all outputs 0; request register, tag queue, FIFO, and discard counter cleared.
- Credit: issue allowed when req_pending + tag_count + fifo_count < FIFO_DEPTH and tag_count < MAX_OUTSTANDING (and not blocked by discard, below). Overflow is impossible by construction.
- Issue: if no request pending, credit available, reg_pc_valid=1 and branch_flush=0, register mem_addr={reg_pc[AW-1:2],2'b00}, saved_pc={reg_pc[AW-1:1],1'b0}, and assert mem_read_valid next cycle. reg_pc[0] is ignored.
- Request hold: mem_addr and mem_read_valid stay stable until mem_read_valid&&mem_ready. On accept, push saved_pc into the tag queue and drop mem_read_valid. If reg_pc_valid and credit allow, a new request may be loaded in the same cycle, giving back-to-back issue at one per cycle.
- Response: on mem_data_valid, pop the tag queue.
  - If discard_cnt>0: decrement it and drop the data.
  - Otherwise push {halfword, tag_pc} into the FIFO one cycle later. halfword = mem_data[15:0] if tag_pc[1]=0, else mem_data[31:16] (little-endian).
- Output: inst_* reflect the FIFO head, registered. Pop when inst_valid_out&&ifetch_ready. Push and pop in the same cycle are allowed.
- Latency: reg_pc_valid at cycle N → mem_read_valid at N+1. With mem_ready at N+1 and mem_data_valid at N+2 → inst_valid_out at N+3.
- branch_flush (highest priority, single cycle):
  - FIFO emptied; inst_valid_out=0 next cycle.
  - Unaccepted pending request withdrawn (mem_read_valid=0 next cycle).
  - discard_cnt <= tag_count + (request accepted this cycle) − (response arriving this cycle).
  - A response arriving in the flush cycle is dropped.
  - No new issue in the flush cycle. Issue resumes next cycle even while discard_cnt>0; credits count the discarded reads.
- mem_data_valid with empty tag queue: ignored (simulation assertion).
- Reset mid-transaction: state cleared immediately. The bus owner must also be reset; late responses are not tracked.
- imem_busy = mem_read_valid | (tag_count≠0) | (discard_cnt≠0).

Decomposition:
- Shared core package: ADDR_WIDTH/INST_WIDTH defaults, START_PC, halfword-select constants, tag record type {pc}.
- One sub-module: w0rm_sync_fifo (parameterised width/depth, count output). Instantiated twice: tag queue (width ADDR_WIDTH, depth MAX_OUTSTANDING) and output FIFO (width INST_WIDTH+ADDR_WIDTH, depth FIFO_DEPTH).

Test Plan:
- Zero-wait streaming: reg_pc 0x2000_0000, 0x2000_0002, 0x2000_0004 with ifetch_ready=1 and memory returning word 0xBBBB_AAAA then 0xDDDD_CCCC → inst_data 0xAAAA@0x2000_0000, 0xBBBB@0x2000_0002, 0xCCCC@0x2000_0004; first valid 3 cycles after reg_pc_valid.
- Backpressure: ifetch_ready=0 with FIFO_DEPTH=2 → exactly 2 reads issued, mem_read_valid stays 0 and the FIFO holds both entries. Raise ifetch_ready → entries drain in order and issue resumes.
- Bus stall: mem_ready=0 for 5 cycles → mem_addr/mem_read_valid stable throughout; a single tag pushed on accept.
- Flush in flight: 2 reads outstanding, branch_flush, then next reg_pc 0x2000_0100 → both stale responses dropped (discard_cnt 2→0); first inst_addr_out=0x2000_0100.
- Flush coincident with response and with a pending unaccepted request → the response is dropped, the request is withdrawn, and discard_cnt equals the remaining outstanding count.
- Async reset asserted mid-stream between clock edges → all outputs 0 immediately; after release, fetch restarts cleanly from the new reg_pc.

Source files
------------

// File: rtl/w0rm_core_imem_port_pkg.sv
// w0rm core instruction-memory port: shared widths, constants and types.
// Little-endian halfword select and the in-flight read tag record.
package w0rm_core_imem_port_pkg;

   localparam int CORE_ADDR_WIDTH = 32;
   localparam int CORE_DATA_WIDTH = 32;
   localparam int CORE_INST_WIDTH = 16;

   localparam logic [CORE_ADDR_WIDTH-1:0] START_PC = 32'h2000_0000;

   localparam logic HW_LO = 1'b0;
   localparam logic HW_HI = 1'b1;

   typedef struct packed {
      logic [CORE_ADDR_WIDTH-1:0] pc;
   } tag_t;

   function automatic logic [CORE_INST_WIDTH-1:0] select_hw(
      input logic [CORE_DATA_WIDTH-1:0] word,
      input logic                       sel
   );
      logic [CORE_INST_WIDTH-1:0] hw;
      hw = word[15:0];
      unique case (sel)
         HW_LO: hw = word[15:0];
         HW_HI: hw = word[31:16];
      endcase
      return hw;
   endfunction

endpackage

// File: rtl/w0rm_core_imem_port_if.sv
// Instruction bus between the imem port (master) and memory (slave).
// Reads are word aligned; responses return in order.
interface w0rm_core_imem_port_if
   import w0rm_core_imem_port_pkg::*;
#(
   parameter int ADDR_WIDTH = CORE_ADDR_WIDTH,
   parameter int DATA_WIDTH = CORE_DATA_WIDTH
);

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_read_valid;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_data_valid;

   modport master (
      output mem_addr,
      output mem_read_valid,
      input  mem_ready,
      input  mem_data,
      input  mem_data_valid
   );

   modport slave (
      input  mem_addr,
      input  mem_read_valid,
      output mem_ready,
      output mem_data,
      output mem_data_valid
   );

endinterface

// File: rtl/w0rm_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a flush input.
// Head is read straight from storage; a push into a full FIFO needs a pop.
module w0rm_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/w0rm_core_imem_port.sv
// Instruction-memory request/response port feeding the fetch stage.
// Issues word reads, tags them with the halfword PC, buffers instructions.
module w0rm_core_imem_port
   import w0rm_core_imem_port_pkg::*;
#(
   parameter int ADDR_WIDTH      = CORE_ADDR_WIDTH,
   parameter int DATA_WIDTH      = CORE_DATA_WIDTH,
   parameter int INST_WIDTH      = CORE_INST_WIDTH,
   parameter int MAX_OUTSTANDING = 2,
   parameter int FIFO_DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] reg_pc,
   input  logic                  reg_pc_valid,
   input  logic                  ifetch_ready,
   input  logic                  branch_flush,
   w0rm_core_imem_port_if.master bus,
   output logic [INST_WIDTH-1:0] inst_data_out,
   output logic                  inst_valid_out,
   output logic [ADDR_WIDTH-1:0] inst_addr_out,
   output logic                  imem_busy
);

   localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int EW  = INST_WIDTH + ADDR_WIDTH;

   logic                  req_pending;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [ADDR_WIDTH-1:0] saved_pc;
   logic [TCW-1:0]        discard_cnt;

   logic [TCW-1:0]        tag_count;
   logic                  tag_empty;
   tag_t                  tag_in;
   tag_t                  tag_head;
   logic [ADDR_WIDTH-1:0] tag_pc;

   logic [FCW-1:0]        fifo_count;
   logic                  fifo_empty;
   logic [EW-1:0]         ent_in;
   logic [EW-1:0]         ent_head;
   logic [INST_WIDTH-1:0] hw;

   logic accept;
   logic resp;
   logic credit;
   logic load;
   logic fifo_push;
   logic fifo_pop;
   int   occ;

   assign accept = req_pending & bus.mem_ready;
   assign resp   = bus.mem_data_valid & ~tag_empty;

   // Discarded reads still hold credit until their responses drain.
   always_comb begin
      occ    = int'(req_pending) + int'(tag_count) + int'(fifo_count);
      credit = (occ < FIFO_DEPTH) &&
               (int'(tag_count) + int'(req_pending) < MAX_OUTSTANDING);
   end

   assign load = (~req_pending | accept) & credit &
                 reg_pc_valid & ~branch_flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_pending <= 1'b0;
         req_addr    <= '0;
         saved_pc    <= ADDR_WIDTH'(START_PC);
         discard_cnt <= '0;
      end else if (branch_flush) begin
         req_pending <= 1'b0;
         discard_cnt <= tag_count + TCW'(accept) - TCW'(resp);
      end else begin
         if (load) begin
            req_pending <= 1'b1;
            req_addr    <= reg_pc & ~ADDR_WIDTH'(3);
            saved_pc    <= reg_pc & ~ADDR_WIDTH'(1);
         end else if (accept) begin
            req_pending <= 1'b0;
         end
         if (resp && discard_cnt != '0)
            discard_cnt <= discard_cnt - TCW'(1);
      end
   end

   assign tag_in = tag_t'(CORE_ADDR_WIDTH'(saved_pc));
   assign tag_pc = ADDR_WIDTH'(tag_head.pc);

   w0rm_sync_fifo #(
      .WIDTH ($bits(tag_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_q (
      .clk       (clk),
      .reset     (reset),
      .clear     (1'b0),
      .push      (accept),
      .push_data (tag_in),
      .pop       (resp),
      .head      (tag_head),
      .count     (tag_count),
      .empty     (tag_empty)
   );

   assign hw = INST_WIDTH'(select_hw(CORE_DATA_WIDTH'(bus.mem_data),
                                     tag_pc[1]));

   assign ent_in    = {hw, tag_pc};
   assign fifo_push = resp & (discard_cnt == '0) & ~branch_flush;
   assign fifo_pop  = inst_valid_out & ifetch_ready;

   w0rm_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_out_q (
      .clk       (clk),
      .reset     (reset),
      .clear     (branch_flush),
      .push      (fifo_push),
      .push_data (ent_in),
      .pop       (fifo_pop),
      .head      (ent_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign inst_valid_out = ~fifo_empty;
   assign inst_data_out  = inst_valid_out ? ent_head[EW-1:ADDR_WIDTH] : '0;
   assign inst_addr_out  = inst_valid_out ? ent_head[ADDR_WIDTH-1:0] : '0;

   assign bus.mem_addr       = req_addr;
   assign bus.mem_read_valid = req_pending;

   assign imem_busy = req_pending | (tag_count != '0) | (discard_cnt != '0);

   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(bus.mem_data_valid && tag_empty))
         else $error("imem response with no outstanding read");
   end

endmodule

// File: tb/tb_w0rm_core_imem_port.sv
// Directed bench for w0rm_core_imem_port: streaming, backpressure,
// bus stall, flushes and asynchronous reset, with hand-computed values.
module tb_w0rm_core_imem_port;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] reg_pc;
   logic        reg_pc_valid;
   logic        ifetch_ready;
   logic        branch_flush;
   logic [15:0] inst_data_out;
   logic        inst_valid_out;
   logic [31:0] inst_addr_out;
   logic        imem_busy;

   int passed = 0;
   int total  = 0;

   w0rm_core_imem_port_if bus ();

   w0rm_core_imem_port dut (
      .clk            (clk),
      .reset          (reset),
      .reg_pc         (reg_pc),
      .reg_pc_valid   (reg_pc_valid),
      .ifetch_ready   (ifetch_ready),
      .branch_flush   (branch_flush),
      .bus            (bus),
      .inst_data_out  (inst_data_out),
      .inst_valid_out (inst_valid_out),
      .inst_addr_out  (inst_addr_out),
      .imem_busy      (imem_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      reset              = 1'b1;
      reg_pc             = '0;
      reg_pc_valid       = 1'b0;
      ifetch_ready       = 1'b0;
      branch_flush       = 1'b0;
      bus.mem_ready      = 1'b0;
      bus.mem_data       = '0;
      bus.mem_data_valid = 1'b0;
      step();
      step();
      chk("rst_rv", bus.mem_read_valid, 0);
      chk("rst_maddr", bus.mem_addr, 0);
      chk("rst_iv", inst_valid_out, 0);
      chk("rst_idata", inst_data_out, 0);
      chk("rst_iaddr", inst_addr_out, 0);
      chk("rst_busy", imem_busy, 0);
      reset = 1'b0;
      step();

      // zero-wait streaming
      ifetch_ready  = 1'b1;
      bus.mem_ready = 1'b1;
      reg_pc        = 32'h2000_0000;
      reg_pc_valid  = 1'b1;
      step();
      chk("s_rv1", bus.mem_read_valid, 1);
      chk("s_addr1", bus.mem_addr, 32'h2000_0000);
      reg_pc = 32'h2000_0002;
      step();
      chk("s_rv2", bus.mem_read_valid, 1);
      chk("s_addr2", bus.mem_addr, 32'h2000_0000);
      chk("s_iv_early", inst_valid_out, 0);
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'hBBBB_AAAA;
      reg_pc             = 32'h2000_0004;
      step();
      chk("s_iv_a", inst_valid_out, 1);
      chk("s_data_a", inst_data_out, 16'hAAAA);
      chk("s_iaddr_a", inst_addr_out, 32'h2000_0000);
      chk("s_rv_full", bus.mem_read_valid, 0);
      step();
      chk("s_data_b", inst_data_out, 16'hBBBB);
      chk("s_iaddr_b", inst_addr_out, 32'h2000_0002);
      chk("s_rv_full2", bus.mem_read_valid, 0);
      bus.mem_data_valid = 1'b0;
      step();
      chk("s_rv3", bus.mem_read_valid, 1);
      chk("s_addr3", bus.mem_addr, 32'h2000_0004);
      chk("s_iv_gap", inst_valid_out, 0);
      reg_pc_valid = 1'b0;
      step();
      chk("s_rv_acc", bus.mem_read_valid, 0);
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'hDDDD_CCCC;
      step();
      chk("s_data_c", inst_data_out, 16'hCCCC);
      chk("s_iaddr_c", inst_addr_out, 32'h2000_0004);
      bus.mem_data_valid = 1'b0;
      step();
      chk("s_iv_end", inst_valid_out, 0);
      chk("s_busy_end", imem_busy, 0);

      // backpressure
      ifetch_ready = 1'b0;
      reg_pc       = 32'h2000_0010;
      reg_pc_valid = 1'b1;
      step();
      chk("bp_rv1", bus.mem_read_valid, 1);
      chk("bp_addr1", bus.mem_addr, 32'h2000_0010);
      reg_pc = 32'h2000_0012;
      step();
      chk("bp_rv2", bus.mem_read_valid, 1);
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'h2222_1111;
      reg_pc             = 32'h2000_0014;
      step();
      chk("bp_rv_stop", bus.mem_read_valid, 0);
      chk("bp_data_a", inst_data_out, 16'h1111);
      step();
      bus.mem_data_valid = 1'b0;
      step();
      step();
      chk("bp_rv_hold", bus.mem_read_valid, 0);
      chk("bp_iv_hold", inst_valid_out, 1);
      chk("bp_data_hold", inst_data_out, 16'h1111);
      chk("bp_iaddr_hold", inst_addr_out, 32'h2000_0010);
      chk("bp_busy_hold", imem_busy, 0);
      ifetch_ready = 1'b1;
      step();
      chk("bp_data_b", inst_data_out, 16'h2222);
      chk("bp_iaddr_b", inst_addr_out, 32'h2000_0012);
      chk("bp_rv_still", bus.mem_read_valid, 0);
      step();
      chk("bp_rv_resume", bus.mem_read_valid, 1);
      chk("bp_addr_resume", bus.mem_addr, 32'h2000_0014);
      chk("bp_iv_drained", inst_valid_out, 0);
      reg_pc_valid = 1'b0;
      step();
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'h4444_3333;
      step();
      chk("bp_data_c", inst_data_out, 16'h3333);
      chk("bp_iaddr_c", inst_addr_out, 32'h2000_0014);
      bus.mem_data_valid = 1'b0;
      step();
      chk("bp_iv_end", inst_valid_out, 0);

      // bus stall
      bus.mem_ready = 1'b0;
      reg_pc        = 32'h2000_0022;
      reg_pc_valid  = 1'b1;
      step();
      reg_pc_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("st_rv", bus.mem_read_valid, 1);
         chk("st_addr", bus.mem_addr, 32'h2000_0020);
         step();
      end
      bus.mem_ready = 1'b1;
      step();
      chk("st_rv_acc", bus.mem_read_valid, 0);
      chk("st_busy_tag", imem_busy, 1);
      bus.mem_ready      = 1'b0;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'h5555_6666;
      step();
      chk("st_data", inst_data_out, 16'h5555);
      chk("st_iaddr", inst_addr_out, 32'h2000_0022);
      chk("st_busy_done", imem_busy, 0);
      bus.mem_data_valid = 1'b0;
      step();
      chk("st_iv_end", inst_valid_out, 0);

      // flush with two reads in flight
      bus.mem_ready = 1'b1;
      reg_pc        = 32'h2000_0040;
      reg_pc_valid  = 1'b1;
      step();
      chk("fl_rv1", bus.mem_read_valid, 1);
      reg_pc = 32'h2000_0044;
      step();
      reg_pc_valid = 1'b0;
      step();
      chk("fl_rv_out", bus.mem_read_valid, 0);
      chk("fl_busy_out", imem_busy, 1);
      branch_flush = 1'b1;
      step();
      branch_flush = 1'b0;
      chk("fl_busy_disc", imem_busy, 1);
      chk("fl_iv", inst_valid_out, 0);
      reg_pc             = 32'h2000_0100;
      reg_pc_valid       = 1'b1;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'hDEAD_BEEF;
      step();
      chk("fl_no_credit", bus.mem_read_valid, 0);
      chk("fl_drop1", inst_valid_out, 0);
      step();
      chk("fl_rv_new", bus.mem_read_valid, 1);
      chk("fl_addr_new", bus.mem_addr, 32'h2000_0100);
      chk("fl_drop2", inst_valid_out, 0);
      bus.mem_data_valid = 1'b0;
      reg_pc_valid       = 1'b0;
      step();
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'h7777_8888;
      chk("fl_iv_wait", inst_valid_out, 0);
      step();
      chk("fl_data", inst_data_out, 16'h8888);
      chk("fl_iaddr", inst_addr_out, 32'h2000_0100);
      bus.mem_data_valid = 1'b0;
      step();
      chk("fl_iv_end", inst_valid_out, 0);
      chk("fl_busy_end", imem_busy, 0);

      // flush with a response and an unaccepted request
      reg_pc       = 32'h2000_0200;
      reg_pc_valid = 1'b1;
      step();
      reg_pc = 32'h2000_0204;
      step();
      chk("fc_rv_b", bus.mem_read_valid, 1);
      chk("fc_addr_b", bus.mem_addr, 32'h2000_0204);
      bus.mem_ready = 1'b0;
      reg_pc_valid  = 1'b0;
      step();
      chk("fc_rv_held", bus.mem_read_valid, 1);
      branch_flush       = 1'b1;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'h1234_5678;
      step();
      branch_flush       = 1'b0;
      bus.mem_data_valid = 1'b0;
      chk("fc_rv_wd", bus.mem_read_valid, 0);
      chk("fc_iv", inst_valid_out, 0);
      chk("fc_busy", imem_busy, 0);

      // flush with a response while two reads are outstanding
      bus.mem_ready = 1'b1;
      reg_pc        = 32'h2000_0300;
      reg_pc_valid  = 1'b1;
      step();
      reg_pc = 32'h2000_0302;
      step();
      reg_pc_valid = 1'b0;
      step();
      branch_flush       = 1'b1;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'hCAFE_F00D;
      step();
      branch_flush = 1'b0;
      chk("fd_busy_one", imem_busy, 1);
      chk("fd_iv", inst_valid_out, 0);
      reg_pc       = 32'h2000_0400;
      reg_pc_valid = 1'b1;
      step();
      bus.mem_data_valid = 1'b0;
      reg_pc_valid       = 1'b0;
      chk("fd_rv_new", bus.mem_read_valid, 1);
      chk("fd_addr_new", bus.mem_addr, 32'h2000_0400);
      chk("fd_drop", inst_valid_out, 0);
      step();
      ifetch_ready       = 1'b0;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'h1357_2468;
      step();
      bus.mem_data_valid = 1'b0;
      chk("fd_data", inst_data_out, 16'h2468);
      chk("fd_iaddr", inst_addr_out, 32'h2000_0400);
      chk("fd_busy_end", imem_busy, 0);

      // asynchronous reset between edges
      reg_pc       = 32'h2000_0404;
      reg_pc_valid = 1'b1;
      step();
      chk("ar_rv_pre", bus.mem_read_valid, 1);
      chk("ar_iv_pre", inst_valid_out, 1);
      reg_pc_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("ar_rv", bus.mem_read_valid, 0);
      chk("ar_maddr", bus.mem_addr, 0);
      chk("ar_iv", inst_valid_out, 0);
      chk("ar_idata", inst_data_out, 0);
      chk("ar_iaddr", inst_addr_out, 0);
      chk("ar_busy", imem_busy, 0);
      step();
      reset         = 1'b0;
      ifetch_ready  = 1'b1;
      bus.mem_ready = 1'b1;
      reg_pc        = 32'h2000_0500;
      reg_pc_valid  = 1'b1;
      step();
      chk("ar_rv_new", bus.mem_read_valid, 1);
      chk("ar_addr_new", bus.mem_addr, 32'h2000_0500);
      reg_pc_valid = 1'b0;
      step();
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 32'h9999_AAAA;
      step();
      chk("ar_data", inst_data_out, 16'hAAAA);
      chk("ar_iaddr_new", inst_addr_out, 32'h2000_0500);
      bus.mem_data_valid = 1'b0;
      step();
      chk("ar_iv_end", inst_valid_out, 0);
      chk("ar_busy_end", imem_busy, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
